// File: rtl/arb_pkg.sv
// Shared types and constants for the main memory bus arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANTED,
    ARB_OWNED,
    ARB_RELEASE
  } arb_state_t;

  localparam int ARB_MAX_REQ = 8;

  localparam int MSTR_IWALK  = 0;
  localparam int MSTR_DWALK  = 1;
  localparam int MSTR_ICACHE = 2;
  localparam int MSTR_DCACHE = 3;

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner select: first set request at or above ptr, wrapping to 0.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx,
  output logic [NUM_REQ-1:0] onehot
);

  logic [NUM_REQ-1:0] rot;
  int unsigned        pos;

  always_comb begin
    // Rotating the doubled vector puts rr_ptr's request at bit 0.
    rot    = NUM_REQ'({req, req} >> ptr);
    found  = 1'b0;
    idx    = '0;
    onehot = '0;
    pos    = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        pos   = 32'(ptr) + i;
        if (pos >= unsigned'(NUM_REQ)) pos = pos - unsigned'(NUM_REQ);
        idx    = IDX_W'(pos);
        onehot = NUM_REQ'(1) << pos;
      end
    end
  end

endmodule

// File: rtl/main_bus_arbiter.sv
// Round-robin owner arbiter for the main memory bus with registered one-hot grant.
// Optional grant timeout enabled by defining ARB_TIMEOUT_EN.
module main_bus_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int IDX_W         = $clog2(NUM_REQ),
  parameter int GRANT_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] abtr_reqcyc,
  input  logic [NUM_REQ-1:0] bus_busy,
  output logic [NUM_REQ-1:0] abtr_grant,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               timeout_err
);

  if (NUM_REQ < 2 || NUM_REQ > ARB_MAX_REQ || GRANT_TIMEOUT < 1) begin : g_cfg_err
    $error("main_bus_arbiter: unsupported NUM_REQ or GRANT_TIMEOUT");
  end

  arb_state_t         state;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   rr_ptr;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_onehot;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req    (abtr_reqcyc),
    .ptr    (rr_ptr),
    .found  (pick_found),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  assign grant_valid = |abtr_grant;

`ifdef ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(GRANT_TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB_IDLE;
      abtr_grant <= '0;
      grant_idx  <= '0;
      owner      <= '0;
      rr_ptr     <= '0;
`ifdef ARB_TIMEOUT_EN
      to_cnt      <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        ARB_IDLE: begin
          if (pick_found) begin
            state      <= ARB_GRANTED;
            owner      <= pick_idx;
            grant_idx  <= pick_idx;
            abtr_grant <= pick_onehot;
`ifdef ARB_TIMEOUT_EN
            to_cnt <= '0;
`endif
          end
        end
        ARB_GRANTED: begin
          if (bus_busy[owner]) begin
            state <= ARB_OWNED;
          end else if (!abtr_reqcyc[owner]) begin
            state      <= ARB_RELEASE;
            abtr_grant <= '0;
            grant_idx  <= '0;
          end
`ifdef ARB_TIMEOUT_EN
          else if (to_cnt == TO_W'(GRANT_TIMEOUT - 1)) begin
            state       <= ARB_RELEASE;
            abtr_grant  <= '0;
            grant_idx   <= '0;
            timeout_err <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        ARB_OWNED: begin
          if (!abtr_reqcyc[owner] && !bus_busy[owner]) begin
            state      <= ARB_RELEASE;
            abtr_grant <= '0;
            grant_idx  <= '0;
          end
        end
        ARB_RELEASE: begin
          rr_ptr <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
          state  <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_main_bus_arbiter.sv
// Directed plus randomized bench for main_bus_arbiter against a cycle-level ownership model.
module tb_main_bus_arbiter;

  localparam int N  = 4;
  localparam int IW = $clog2(N);
  localparam int TO = 16;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic [N-1:0]  busy;
  logic [N-1:0]  grant;
  logic          gv;
  logic [IW-1:0] gidx;
  logic          terr;

  always #5 clk = ~clk;

  main_bus_arbiter #(
    .NUM_REQ       (N),
    .GRANT_TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .abtr_reqcyc (req),
    .bus_busy    (busy),
    .abtr_grant  (grant),
    .grant_valid (gv),
    .grant_idx   (gidx),
    .timeout_err (terr)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the bus, whether it has started a transfer,
  // how long it has waited, and whether the bus is in its turnaround cycle.
  int m_owner = -1;
  bit m_turn  = 1'b0;
  int m_last  = 0;
  int m_rr    = 0;
  bit m_xfer  = 1'b0;
  int m_wait  = 0;
  bit m_pulse = 1'b0;

  function automatic void model_step(logic rst, logic [N-1:0] r, logic [N-1:0] b);
    bit rel;
    bit got;
    m_pulse = 1'b0;
    rel     = 1'b0;
    if (rst) begin
      m_owner = -1;
      m_turn  = 1'b0;
      m_rr    = 0;
    end else if (m_turn) begin
      m_turn = 1'b0;
      m_rr   = (m_last + 1) % N;
    end else if (m_owner < 0) begin
      got = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (!got && r[(m_rr + k) % N]) begin
          got     = 1'b1;
          m_owner = (m_rr + k) % N;
          m_xfer  = 1'b0;
          m_wait  = 0;
        end
      end
    end else if (!m_xfer) begin
      if (b[m_owner]) m_xfer = 1'b1;
      else if (!r[m_owner]) rel = 1'b1;
      else begin
        m_wait++;
        if (TO_EN && m_wait >= TO) begin
          rel     = 1'b1;
          m_pulse = 1'b1;
        end
      end
    end else if (!r[m_owner] && !b[m_owner]) begin
      rel = 1'b1;
    end
    if (rel) begin
      m_last  = m_owner;
      m_owner = -1;
      m_turn  = 1'b1;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] eg;
    eg = (m_owner >= 0) ? N'(1) << m_owner : '0;
    chk("grant", 32'(grant), 32'(eg));
    chk("grant_valid", 32'(gv), 32'(m_owner >= 0));
    chk("grant_idx", 32'(gidx), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    chk("timeout_err", 32'(terr), 32'(m_pulse));
    chk("onehot0", 32'($onehot0(grant)), 32'd1);
    chk("valid_or", 32'(gv), 32'(|grant));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(reset, req, busy);
    #1;
    check_outputs();
  endtask

  int order [5];
  int gap;
  int guard;
  int held;
  int pulses;
  int idx;

  initial begin
    reset = 1'b1;
    req   = '1;
    busy  = '0;

    // Reset held with all requests: no grant, then master 0 first.
    repeat (3) begin
      tick();
      chk("reset_grant", 32'(grant), 32'd0);
    end
    reset = 1'b0;
    tick();
    chk("first_after_reset", 32'(grant), 32'b0001);
    req = '0;
    repeat (3) tick();

    // Single master with a transfer.
    req = 4'b0100;
    tick();
    chk("single_grant", 32'(grant), 32'b0100);
    tick();
    busy = 4'b0100;
    tick();
    req = '0;
    repeat (6) tick();
    chk("single_held", 32'(grant), 32'b0100);
    busy = '0;
    tick();
    chk("single_release", 32'(grant), 32'd0);
    repeat (2) tick();

    // Wrap-around from rr_ptr=3.
    req = 4'b0011;
    tick();
    chk("wrap_first", 32'(grant), 32'b0001);
    busy = 4'b0001;
    req  = 4'b0010;
    tick();
    busy = '0;
    tick();
    tick();
    tick();
    chk("wrap_next", 32'(grant), 32'b0010);

    // Cancel before any transfer.
    req = '0;
    tick();
    chk("cancel_release", 32'(grant), 32'd0);
    req = 4'b0111;
    tick();
    tick();
    chk("cancel_ptr", 32'(grant), 32'b0100);
    req = '0;
    repeat (3) tick();

    // Fairness from reset with all masters requesting.
    reset = 1'b1;
    req   = '1;
    tick();
    reset = 1'b0;
    tick();
    for (int o = 0; o < 5; o++) begin
      gap   = (o == 0) ? 0 : 1;
      guard = 0;
      while (!gv && guard < 20) begin
        tick();
        if (!gv) gap++;
        guard++;
      end
      chk("fair_wait", 32'(guard < 20), 32'd1);
      if (o > 0) chk("fair_gap", 32'(gap), 32'd2);
      order[o] = int'(gidx);
      idx  = int'(gidx);
      busy = N'(1) << idx;
      req[idx] = 1'b0;
      repeat (4) tick();
      busy = '0;
      tick();
      req[idx] = 1'b1;
    end
    chk("fair_0", 32'(order[0]), 32'd0);
    chk("fair_1", 32'(order[1]), 32'd1);
    chk("fair_2", 32'(order[2]), 32'd2);
    chk("fair_3", 32'(order[3]), 32'd3);
    chk("fair_4", 32'(order[4]), 32'd0);
    req = '0;
    repeat (3) tick();

    // Granted master that never starts a transfer.
    req = 4'b1000;
    tick();
    chk("to_grant", 32'(grant), 32'b1000);
    req = 4'b1001;
`ifdef ARB_TIMEOUT_EN
    held   = 1;
    pulses = 0;
    guard  = 0;
    while (grant == 4'b1000 && guard < 40) begin
      tick();
      if (grant == 4'b1000) held++;
      if (terr) pulses++;
      guard++;
    end
    chk("to_held", 32'(held), 32'(TO));
    guard = 0;
    while (!gv && guard < 10) begin
      tick();
      if (terr) pulses++;
      guard++;
    end
    chk("to_pulses", 32'(pulses), 32'd1);
    chk("to_next", 32'(grant), 32'b0001);
`else
    repeat (110) tick();
    chk("no_to_held", 32'(grant), 32'b1000);
    chk("no_to_err", 32'(terr), 32'd0);
`endif
    req = '0;
    repeat (3) tick();

    // Randomized traffic; busy only ever from the current owner.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      req   = N'($urandom) & N'($urandom);
      busy  = '0;
      if (m_owner >= 0 && !m_turn) begin
        if ($urandom_range(0, 3) != 0) req[m_owner] = 1'b1;
        if ($urandom_range(0, 2) == 0) busy[m_owner] = 1'b1;
        if (m_xfer && $urandom_range(0, 4) == 0) begin
          req[m_owner]  = 1'b0;
          busy[m_owner] = 1'b0;
        end
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
